// File: rtl/i2c_read_sched.sv
// i2c_read_sched: schedules temperature reads through a byte-level I2C master.
// Periodic poll plus host requests, NACK/timeout retry with backoff.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   host_req / host_ack   host read request pulse / completion pulse
//   m_start, m_addr, m_rw master command (start pulse, address, read)
//   m_busy, m_done,       master status; m_nack and m_rdata are
//   m_nack, m_rdata       valid only with m_done
//   temp, temp_valid, err latest good sample and status
//   retry_cnt             retries used by current/last request
module i2c_read_sched #(
  parameter int unsigned POLL_PERIOD = 100000,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned BACKOFF_CYC = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_req,
  output logic       host_ack,
  output logic       m_start,
  output logic [6:0] m_addr,
  output logic       m_rw,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_nack,
  input  logic [7:0] m_rdata,
  output logic [7:0] temp,
  output logic       temp_valid,
  output logic       err,
  output logic [2:0] retry_cnt
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = $clog2(BACKOFF_CYC + 1);

  localparam logic [PW-1:0] TICK_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BO_LAST   = BW'(BACKOFF_CYC);
  localparam logic [2:0]    MAXR      = 3'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] tick_cnt_q, tick_cnt_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic [BW-1:0] bo_cnt_q, bo_cnt_d;
  logic          poll_pend_q, poll_pend_d;
  logic          host_pend_q, host_pend_d;
  logic          serve_host_q, serve_host_d;
  logic          serve_poll_q, serve_poll_d;
  logic [2:0]    retry_q, retry_d;
  logic [7:0]    temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          ack_q, ack_d;

  logic tick;
  logic want;
  logic consume;
  logic fail;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign want    = host_req | host_pend_q | tick | poll_pend_q;
  assign consume = (state_q == S_IDLE) & want & ~m_busy;

  always_comb begin
    state_d      = state_q;
    wd_cnt_d     = wd_cnt_q;
    bo_cnt_d     = bo_cnt_q;
    serve_host_d = serve_host_q;
    serve_poll_d = serve_poll_q;
    retry_d      = retry_q;
    temp_d       = temp_q;
    valid_d      = valid_q;
    err_d        = err_q;
    ack_d        = 1'b0;
    fail         = 1'b0;

    tick_cnt_d = tick ? '0 : tick_cnt_q + PW'(1);

    // Requests not taken this cycle coalesce into one pending flag.
    host_pend_d = consume ? 1'b0 : (host_pend_q | host_req);
    poll_pend_d = consume ? 1'b0 : (poll_pend_q | tick);

    unique case (state_q)
      S_IDLE: begin
        if (consume) begin
          state_d      = S_ISSUE;
          serve_host_d = host_req | host_pend_q;
          serve_poll_d = tick | poll_pend_q;
          retry_d      = '0;
        end
      end
      S_ISSUE: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + TW'(1);
        // m_done takes priority over a coincident timeout.
        if (m_done) begin
          if (!m_nack) begin
            temp_d  = m_rdata;
            valid_d = 1'b1;
            err_d   = 1'b0;
            ack_d   = serve_host_q;
            state_d = S_IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (wd_cnt_q == WD_LAST) begin
          fail = 1'b1;
        end
        if (fail) begin
          if (retry_q < MAXR) begin
            retry_d  = retry_q + 3'd1;
            bo_cnt_d = '0;
            state_d  = S_BACKOFF;
          end else begin
            err_d   = 1'b1;
            ack_d   = serve_host_q;
            state_d = S_IDLE;
          end
        end
      end
      S_BACKOFF: begin
        // Retries skip the m_busy check.
        if (bo_cnt_q == BO_LAST) begin
          state_d = S_ISSUE;
        end else begin
          bo_cnt_d = bo_cnt_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      bo_cnt_q     <= '0;
      poll_pend_q  <= 1'b0;
      host_pend_q  <= 1'b0;
      serve_host_q <= 1'b0;
      serve_poll_q <= 1'b0;
      retry_q      <= '0;
      temp_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      bo_cnt_q     <= bo_cnt_d;
      poll_pend_q  <= poll_pend_d;
      host_pend_q  <= host_pend_d;
      serve_host_q <= serve_host_d;
      serve_poll_q <= serve_poll_d;
      retry_q      <= retry_d;
      temp_q       <= temp_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      ack_q        <= ack_d;
    end
  end

  assign m_start    = (state_q == S_ISSUE);
  assign m_addr     = SLAVE_ADDR;
  assign m_rw       = 1'b1;
  assign host_ack   = ack_q;
  assign temp       = temp_q;
  assign temp_valid = valid_q;
  assign err        = err_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_i2c_read_sched.sv
// tb_i2c_read_sched: directed bench for i2c_read_sched.
// Cycle n after reset has poll count n mod 50.
module tb_i2c_read_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_req = 1'b0;
  logic       host_ack;
  logic       m_start;
  logic [6:0] m_addr;
  logic       m_rw;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_nack = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] temp;
  logic       temp_valid;
  logic       err;
  logic [2:0] retry_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ms_cnt = 0;
  int ack_cnt = 0;
  int width_err = 0;
  logic ms_prev = 1'b0;
  logic ack_prev = 1'b0;

  i2c_read_sched #(
    .POLL_PERIOD(50),
    .SLAVE_ADDR (7'h48),
    .MAX_RETRY  (2),
    .BACKOFF_CYC(4),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_req  (host_req),
    .host_ack  (host_ack),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_nack    (m_nack),
    .m_rdata   (m_rdata),
    .temp      (temp),
    .temp_valid(temp_valid),
    .err       (err),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (m_start) begin
      ms_cnt = ms_cnt + 1;
      if (ms_prev) width_err = width_err + 1;
    end
    if (host_ack) begin
      ack_cnt = ack_cnt + 1;
      if (ack_prev) width_err = width_err + 1;
    end
    ms_prev  = m_start;
    ack_prev = host_ack;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) exp %0d (0x%0h) @cyc %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_start(input string tag, input int exp);
    int n = 0;
    while (!m_start && n < 100) begin
      step();
      n++;
    end
    chk(tag, m_start ? cyc : -1, exp);
    m_busy = 1'b1;
  endtask

  task automatic done_at(input int lat, input logic nack,
                         input logic [7:0] d);
    repeat (lat) step();
    m_done  = 1'b1;
    m_nack  = nack;
    m_rdata = d;
    step();
    m_done = 1'b0;
    m_nack = 1'b0;
    m_busy = 1'b0;
  endtask

  int a0;
  int s0;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;

    chk("rst_temp", int'(temp), 0);
    chk("rst_valid", int'(temp_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ack", int'(host_ack), 0);
    chk("rst_mstart", int'(m_start), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_addr", int'(m_addr), 'h48);
    chk("rst_rw", int'(m_rw), 1);

    go_to(10);
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    wait_start("host_start", 11);
    done_at(3, 1'b0, 8'h19);
    chk("host_cyc", cyc, 15);
    chk("host_ack", int'(host_ack), 1);
    chk("host_temp", int'(temp), 'h19);
    chk("host_valid", int'(temp_valid), 1);
    chk("host_err", int'(err), 0);
    step();
    chk("host_ack_low", int'(host_ack), 0);

    a0 = ack_cnt;
    wait_start("poll1_start", 50);
    done_at(3, 1'b0, 8'h1A);
    chk("poll1_temp", int'(temp), 'h1A);
    wait_start("poll2_start", 100);
    done_at(3, 1'b0, 8'h1B);
    chk("poll2_temp", int'(temp), 'h1B);
    chk("poll_no_ack", ack_cnt - a0, 0);

    go_to(149);
    a0 = ack_cnt;
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    wait_start("coin_start", 150);
    done_at(3, 1'b0, 8'h1C);
    chk("coin_ack", int'(host_ack), 1);
    chk("coin_temp", int'(temp), 'h1C);
    step();
    chk("coin_one_ack", ack_cnt - a0, 1);
    s0 = ms_cnt;
    go_to(199);
    chk("coin_no_poll", ms_cnt - s0, 0);

    a0 = ack_cnt;
    wait_start("nack_first", 200);
    done_at(3, 1'b1, 8'hEE);
    chk("nack_retry1", int'(retry_cnt), 1);
    wait_start("nack_retry_start", 209);
    done_at(3, 1'b0, 8'h1D);
    chk("nack_temp", int'(temp), 'h1D);
    chk("nack_err", int'(err), 0);
    chk("nack_retry", int'(retry_cnt), 1);
    chk("nack_no_ack", ack_cnt - a0, 0);

    go_to(220);
    s0 = ms_cnt;
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    wait_start("ex_start0", 221);
    done_at(2, 1'b1, 8'hE0);
    wait_start("ex_start1", 229);
    done_at(2, 1'b1, 8'hE1);
    wait_start("ex_start2", 237);
    done_at(2, 1'b1, 8'hE2);
    chk("ex_cyc", cyc, 240);
    chk("ex_err", int'(err), 1);
    chk("ex_temp", int'(temp), 'h1D);
    chk("ex_ack", int'(host_ack), 1);
    chk("ex_retry", int'(retry_cnt), 2);
    step();
    chk("ex_starts", ms_cnt - s0, 3);
    wait_start("clr_start", 250);
    done_at(3, 1'b0, 8'h1E);
    chk("clr_err", int'(err), 0);
    chk("clr_temp", int'(temp), 'h1E);
    chk("clr_retry", int'(retry_cnt), 0);
    chk("clr_no_ack", int'(host_ack), 0);

    wait_start("mid_poll", 300);
    step();
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    done_at(1, 1'b0, 8'h1F);
    chk("mid_temp", int'(temp), 'h1F);
    chk("mid_no_ack", int'(host_ack), 0);
    wait_start("mid_host_start", 305);
    done_at(3, 1'b0, 8'h20);
    chk("mid_ack", int'(host_ack), 1);
    chk("mid_temp2", int'(temp), 'h20);

    wait_start("tmo_first", 350);
    step();
    wait_start("tmo_retry", 376);
    chk("tmo_retry_cnt", int'(retry_cnt), 1);
    go_to(380);
    rst_n = 1'b0;
    step();
    chk("mid_rst_mstart", int'(m_start), 0);
    chk("mid_rst_ack", int'(host_ack), 0);
    chk("mid_rst_temp", int'(temp), 0);
    chk("mid_rst_valid", int'(temp_valid), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_retry", int'(retry_cnt), 0);
    m_busy = 1'b0;
    rst_n  = 1'b1;

    go_to(5);
    s0 = ms_cnt;
    m_busy   = 1'b1;
    host_req = 1'b1;
    step();
    host_req = 1'b0;
    go_to(10);
    chk("busy_hold", ms_cnt - s0, 0);
    m_busy = 1'b0;
    wait_start("busy_start", 11);
    done_at(2, 1'b0, 8'h21);
    chk("busy_ack", int'(host_ack), 1);
    chk("busy_temp", int'(temp), 'h21);
    chk("busy_valid", int'(temp_valid), 1);
    step();

    chk("pulse_width", width_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
